// File: rtl/divider_if.sv
// Operand/result bundle between the EX stage (master) and the iterative divider (slave).
interface divider_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [2:0]  div_op;
    logic [31:0] div_out;
    logic        div_stall;

    modport master (
        output a, b, start, div_op,
        input  div_out, div_stall
    );

    modport slave (
        input  a, b, start, div_op,
        output div_out, div_stall
    );
endinterface

// File: rtl/divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per cycle.
// Define DIVIDER_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow without iterating.
module divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave dif
);
    localparam int         B    = BITS_PER_CYCLE;
    localparam int         N    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST = 6'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_out_q, div_out_d;
    logic [31:0] dvsr_q, a_q;
    logic        rem_sel_q, q_neg_q, r_neg_q, dz_q, ovf_q;
    logic        stall, load;

    logic        in_signed, in_a_neg, in_b_neg, in_dz, in_ovf;
    logic [31:0] in_a_mag, in_b_mag;

    assign in_signed = ~dif.div_op[0];
    assign in_a_neg  = in_signed & dif.a[31];
    assign in_b_neg  = in_signed & dif.b[31];
    assign in_a_mag  = in_a_neg ? (~dif.a + 32'd1) : dif.a;
    assign in_b_mag  = in_b_neg ? (~dif.b + 32'd1) : dif.b;
    assign in_dz     = (dif.b == 32'd0);
    assign in_ovf    = in_signed && (dif.a == 32'h8000_0000) && (dif.b == 32'hFFFF_FFFF);

    // Architected results for divide-by-zero (dz=1) and signed overflow (dz=0).
    function automatic logic [31:0] special_result(input logic rem_sel, input logic dz,
                                                   input logic [31:0] dividend);
        if (dz)
            return rem_sel ? dividend : 32'hFFFF_FFFF;
        return rem_sel ? 32'd0 : 32'h8000_0000;
    endfunction

    // quo holds the not-yet-consumed dividend bits on top and the quotient bits below.
    logic [31:0] rem_s [B+1];
    logic [31:0] quo_s [B+1];

    assign rem_s[0] = rem_q;
    assign quo_s[0] = quo_q;

    genvar gi;
    generate
        for (gi = 0; gi < B; gi++) begin : g_step
            logic [32:0] pr;
            logic [32:0] diff;

            // pr < 2*divisor always, so diff[32] is set exactly when the trial subtraction borrows.
            assign pr            = {rem_s[gi], quo_s[gi][31]};
            assign diff          = pr - {1'b0, dvsr_q};
            assign rem_s[gi + 1] = diff[32] ? pr[31:0] : diff[31:0];
            assign quo_s[gi + 1] = {quo_s[gi][30:0], ~diff[32]};
        end
    endgenerate

    logic [31:0] q_fin, r_fin, result;

    assign q_fin  = q_neg_q ? (~quo_s[B] + 32'd1) : quo_s[B];
    assign r_fin  = r_neg_q ? (~rem_s[B] + 32'd1) : rem_s[B];
    assign result = (dz_q || ovf_q) ? special_result(rem_sel_q, dz_q, a_q)
                                    : (rem_sel_q ? r_fin : q_fin);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_out_q <= div_out_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        if (load) begin
            dvsr_q    <= in_b_mag;
            a_q       <= dif.a;
            rem_sel_q <= dif.div_op[1];
            q_neg_q   <= in_a_neg ^ in_b_neg;
            r_neg_q   <= in_a_neg;
            dz_q      <= in_dz;
            ovf_q     <= in_ovf;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_out_d = div_out_q;
        stall     = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (dif.start) begin
                    stall   = 1'b1;
                    load    = 1'b1;
                    rem_d   = '0;
                    quo_d   = in_a_mag;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef DIVIDER_FAST_SPECIAL_EN
                    if (in_dz || in_ovf) begin
                        state_d   = DONE;
                        div_out_d = special_result(dif.div_op[1], in_dz, dif.a);
                    end
`endif
                end
            end
            BUSY: begin
                stall = 1'b1;
                rem_d = rem_s[B];
                quo_d = quo_s[B];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    div_out_d = result;
                    state_d   = DONE;
                end
            end
            // start is still high here for the finishing instruction; never relaunch from DONE.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dif.div_stall = stall & ~rst;
    assign dif.div_out   = div_out_q;
endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the divider: timing of stall/result, signed and special cases, reset abort.
`timescale 1ns/1ps
module tb_divider;
    localparam int BPC   = 1;
    localparam int LAT_N = 32 / BPC + 1;
`ifdef DIVIDER_FAST_SPECIAL_EN
    localparam int LAT_SP = 1;
`else
    localparam int LAT_SP = LAT_N;
`endif
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    divider_if dif ();

    divider #(.BITS_PER_CYCLE(BPC)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    // Called at a negedge (cycle T). Returns stall seen in T, cycles until stall drops, and div_out then.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic st, output int lat, output logic [31:0] res);
        dif.div_op = op;
        dif.a      = av;
        dif.b      = bv;
        dif.start  = 1'b1;
        #1 st = dif.div_stall;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                dif.a      = ~av;
                dif.b      = bv ^ 32'h0000_5A5A;
                dif.div_op = op ^ 3'b001;
            end
        end while (dif.div_stall === 1'b1 && lat < 100);
        res = dif.div_out;
        $display("op=%b a=%h b=%h -> div_out=%h stall_T=%b latency=%0d", op, av, bv, res, st, lat);
    endtask

    task automatic test_reset();
        dif.a = 32'd5; dif.b = 32'd1; dif.div_op = OP_DIVU; dif.start = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (dif.div_stall !== 1'b0) begin n_miss++; $display("FAIL reset_stall: got %b expected 0", dif.div_stall); end
        n_vec++; if (dif.div_out !== 32'd0) begin n_miss++; $display("FAIL reset_out: got %h expected 00000000", dif.div_out); end
        rst = 1'b0; dif.start = 1'b0;
        @(negedge clk);
        n_vec++; if (dif.div_stall !== 1'b0) begin n_miss++; $display("FAIL idle_stall: got %b expected 0", dif.div_stall); end
        n_vec++; if (dif.div_out !== 32'd0) begin n_miss++; $display("FAIL idle_out: got %h expected 00000000", dif.div_out); end
        $display("reset: stall=%b div_out=%h", dif.div_stall, dif.div_out);
    endtask

    task automatic test_arith();
        vec_t tbl[7];
        logic st; int lat; logic [31:0] res;
        tbl[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd14,          LAT_N};
        tbl[1] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   LAT_N};
        tbl[2] = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   LAT_N};
        tbl[3] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,   LAT_N};
        tbl[4] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,           LAT_N};
        tbl[5] = '{OP_DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,   LAT_N};
        tbl[6] = '{OP_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,           LAT_N};
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, st, lat, res);
            n_vec++; if (st !== 1'b1) begin n_miss++; $display("FAIL arith%0d_stall_T: got %b expected 1", i, st); end
            n_vec++; if (lat != tbl[i].lat) begin n_miss++; $display("FAIL arith%0d_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            n_vec++; if (res !== tbl[i].exp) begin n_miss++; $display("FAIL arith%0d_result: got %h expected %h", i, res, tbl[i].exp); end
            dif.start = 1'b0;
            repeat (2) @(negedge clk);
            n_vec++; if (dif.div_stall !== 1'b0 || dif.div_out !== tbl[i].exp) begin
                n_miss++; $display("FAIL arith%0d_hold: got stall=%b out=%h expected stall=0 out=%h", i, dif.div_stall, dif.div_out, tbl[i].exp);
            end
        end
    endtask

    task automatic test_special();
        vec_t tbl[8];
        logic st; int lat; logic [31:0] res;
        tbl[0] = '{OP_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678, LAT_SP};
        tbl[1] = '{OP_DIV,  32'h1234_5678, 32'd0,         32'hFFFF_FFFF, LAT_SP};
        tbl[2] = '{OP_DIVU, 32'd42,        32'd0,         32'hFFFF_FFFF, LAT_SP};
        tbl[3] = '{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_SP};
        tbl[4] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP};
        tbl[5] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP};
        tbl[6] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_N};
        tbl[7] = '{OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_N};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, st, lat, res);
            n_vec++; if (st !== 1'b1) begin n_miss++; $display("FAIL special%0d_stall_T: got %b expected 1", i, st); end
            n_vec++; if (lat != tbl[i].lat) begin n_miss++; $display("FAIL special%0d_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            n_vec++; if (res !== tbl[i].exp) begin n_miss++; $display("FAIL special%0d_result: got %h expected %h", i, res, tbl[i].exp); end
            dif.start = 1'b0;
            @(negedge clk);
            n_vec++; if (dif.div_stall !== 1'b0 || dif.div_out !== tbl[i].exp) begin
                n_miss++; $display("FAIL special%0d_hold: got stall=%b out=%h expected stall=0 out=%h", i, dif.div_stall, dif.div_out, tbl[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic st; int lat; logic [31:0] res;
        // start stays high through DONE; the IDLE cycle after it carries the next instruction.
        run_op(OP_DIVU, 32'd1000, 32'd10, st, lat, res);
        n_vec++; if (lat != LAT_N) begin n_miss++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT_N); end
        n_vec++; if (res !== 32'd100) begin n_miss++; $display("FAIL b2b_first_result: got %h expected %h", res, 32'd100); end
        @(negedge clk);
        run_op(OP_REMU, 32'd1000, 32'd7, st, lat, res);
        n_vec++; if (st !== 1'b1) begin n_miss++; $display("FAIL b2b_second_stall_T: got %b expected 1", st); end
        n_vec++; if (lat != LAT_N) begin n_miss++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT_N); end
        n_vec++; if (res !== 32'd6) begin n_miss++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'd6); end
        dif.start = 1'b0;
        @(negedge clk);
        n_vec++; if (dif.div_stall !== 1'b0) begin n_miss++; $display("FAIL b2b_idle_stall: got %b expected 0", dif.div_stall); end
    endtask

    task automatic test_rst_abort();
        logic st; int lat; logic [31:0] res;
        dif.div_op = OP_DIVU; dif.a = 32'd100; dif.b = 32'd7; dif.start = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (dif.div_stall !== 1'b1) begin n_miss++; $display("FAIL abort_busy_stall: got %b expected 1", dif.div_stall); end
        rst = 1'b1;
        #1;
        n_vec++; if (dif.div_stall !== 1'b0) begin n_miss++; $display("FAIL abort_rst_stall: got %b expected 0", dif.div_stall); end
        @(negedge clk);
        n_vec++; if (dif.div_stall !== 1'b0) begin n_miss++; $display("FAIL abort_next_stall: got %b expected 0", dif.div_stall); end
        n_vec++; if (dif.div_out !== 32'd0) begin n_miss++; $display("FAIL abort_next_out: got %h expected 00000000", dif.div_out); end
        $display("abort: rst at T+10 -> stall=%b div_out=%h", dif.div_stall, dif.div_out);
        rst = 1'b0; dif.start = 1'b0;
        @(negedge clk);
        n_vec++; if (dif.div_stall !== 1'b0) begin n_miss++; $display("FAIL abort_idle_stall: got %b expected 0", dif.div_stall); end
        run_op(OP_DIVU, 32'd9, 32'd3, st, lat, res);
        n_vec++; if (lat != LAT_N) begin n_miss++; $display("FAIL abort_fresh_latency: got %0d expected %0d", lat, LAT_N); end
        n_vec++; if (res !== 32'd3) begin n_miss++; $display("FAIL abort_fresh_result: got %h expected %h", res, 32'd3); end
        dif.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        dif.start = 1'b0; dif.a = '0; dif.b = '0; dif.div_op = OP_DIVU;
        test_reset();
        test_arith();
        test_special();
        test_back_to_back();
        test_rst_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, quotient bits retired per iteration cycle; legal values 1 and 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a  input  32  dividend (rs1).
REQ-005 SHALL have port b  input  32  divisor (rs2).
REQ-006 SHALL have port start  input  1  request a division; held high by EX while the instruction occupies the stage.
REQ-007 SHALL have port div_op  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port div_out  output  32  registered result.
REQ-009 SHALL have port div_stall  output  1  pipeline hold request.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 SHALL, in IDLE with start=1, latch a, b and div_op, drive div_stall=1 combinationally in that cycle (T), and move to BUSY.
REQ-012 SHALL, in IDLE with start=0, hold div_stall=0 and keep div_out unchanged.
REQ-013 SHALL stay in BUSY for N=32/BITS_PER_CYCLE cycles (T+1..T+N), counted by an iteration counter, with div_stall=1 throughout.
REQ-014 SHALL enter DONE at T+N+1, driving div_stall=0 and a valid div_out for that cycle, then return to IDLE.
REQ-015 SHALL ignore start while in DONE, so the still-asserted start of the completing instruction does not relaunch.
REQ-016 SHALL ignore changes on a, b and div_op after the start cycle.
REQ-017 SHALL perform unsigned restoring division on magnitudes: a 33-bit partial remainder, and a quotient shifted left BITS_PER_CYCLE bits per cycle.
REQ-018 SHALL, for DIV/REM, take the two's-complement magnitude of negative operands; for DIVU/REMU, treat operands as unsigned.
REQ-019 SHALL negate the signed quotient when operand signs differ, and give the signed remainder the sign of the dividend.
REQ-020 SHALL, for b=0, return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = a (REM and REMU).
REQ-021 SHALL, for DIV/REM with a=0x80000000 and b=0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-022 SHALL select quotient for DIV/DIVU and remainder for REM/REMU into div_out.
REQ-023 SHALL leave div_out holding the last result until the next DONE.

Reset
REQ-024 SHALL, while rst=1, force FSM=IDLE, counter=0, div_out=0 and div_stall=0, regardless of start.
REQ-025 SHALL, on rst in BUSY or DONE, abandon the operation with no partial result visible; the next start begins a fresh division.

Configuration
REQ-026 SHALL compile the special-case fast path only when DIVIDER_FAST_SPECIAL_EN is defined.
REQ-027 SHALL, with DIVIDER_FAST_SPECIAL_EN defined, go IDLE->DONE directly for divide-by-zero and signed overflow: stall in T only, result in T+1.
REQ-028 SHALL, without DIVIDER_FAST_SPECIAL_EN, run all N BUSY cycles for the special cases, then override the result per REQ-020/021; latency is identical to normal operations.

Verification
REQ-029 SHALL cover DIVU, a=100, b=7, BITS_PER_CYCLE=1: stall high T..T+32, div_out=14 at T+33 with stall low.
REQ-030 SHALL cover the signed results for a=-7 (0xFFFFFFF9), b=2: DIV -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-031 SHALL cover REMU with b=0, a=0x12345678: div_out=0x12345678, and DIV with b=0 -> 0xFFFFFFFF; latency 1 with the macro, 33 without.
REQ-032 SHALL cover DIV with a=0x80000000, b=0xFFFFFFFF: div_out=0x80000000; REM -> 0.
REQ-033 SHALL cover start held high through DONE followed by IDLE: exactly one operation completes; a new start at T+34 gives a second result at T+67.
REQ-034 SHALL cover rst asserted at T+10: stall=0 and div_out=0 next cycle; a following DIVU 9/3 returns 3.
